// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: hazard inputs from the pipeline stages, and
// pause/bubble controls, perf counters and timeout flag back to the pipeline.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   // ID / EX / MEM hazard sources
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [4:0]       ex_rd;
   logic             ex_is_load;
   logic             ex_br_taken;
   logic             ex_busy;
   logic             mem_req;
   logic             mem_ready;

   // Pipeline register controls
   logic             pc_pause;
   logic             if_id_pause;
   logic             if_id_bubble;
   logic             id_ex_pause;
   logic             id_ex_bubble;
   logic             ex_mem_pause;
   logic             ex_mem_bubble;
   logic             mem_wb_pause;
   logic             mem_wb_bubble;

   // Status
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             timeout_err;

   // Pipeline side: presents hazards, consumes controls
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
             ex_br_taken, ex_busy, mem_req, mem_ready,
      input  pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
             ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble,
             stall_cnt, flush_cnt, timeout_err
   );

   // Controller side
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
             ex_br_taken, ex_busy, mem_req, mem_ready,
      output pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
             ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble,
             stall_cnt, flush_cnt, timeout_err
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Pause/bubble
// controls are combinational from the hazard inputs and the current state;
// a wait counter freezes the pipeline after TIMEOUT consecutive MEM/EX stalls.
module hazard_ctrl #(
   parameter int unsigned TIMEOUT = 256,
   parameter int unsigned CNT_W   = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   hazard_ctrl_if.slave hif
);

   localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      EX_BUSY  = 2'd2,
      ERR      = 2'd3
   } state_t;

   state_t            r_state;
   logic [WAIT_W-1:0] r_wait;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;
   logic              r_timeout_err;

   logic w_mw;
   logic w_lu;
   logic w_stalled;
   logic w_flush;
   logic w_pc_pause;
   logic w_if_id_pause;
   logic w_if_id_bubble;
   logic w_id_ex_pause;
   logic w_id_ex_bubble;
   logic w_ex_mem_pause;
   logic w_ex_mem_bubble;
   logic w_mem_wb_pause;
   logic w_mem_wb_bubble;

   assign w_mw      = hif.mem_req & ~hif.mem_ready;
   assign w_lu      = hif.ex_is_load && (hif.ex_rd != 5'd0) &&
                      ((hif.id_use_rs1 && (hif.id_rs1 == hif.ex_rd)) ||
                       (hif.id_use_rs2 && (hif.id_rs2 == hif.ex_rd)));
   assign w_stalled = w_mw | hif.ex_busy;
   // A branch held in EX by a MEM/EX stall is only acted on once the stall clears
   assign w_flush   = reset_n && (r_state != ERR) && !w_stalled && hif.ex_br_taken;

   // Prioritised pause/bubble decode; reset forces NOP fill
   always_comb begin
      w_pc_pause      = 1'b0;
      w_if_id_pause   = 1'b0;
      w_if_id_bubble  = 1'b0;
      w_id_ex_pause   = 1'b0;
      w_id_ex_bubble  = 1'b0;
      w_ex_mem_pause  = 1'b0;
      w_ex_mem_bubble = 1'b0;
      w_mem_wb_pause  = 1'b0;
      w_mem_wb_bubble = 1'b0;
      if (!reset_n) begin
         w_if_id_bubble  = 1'b1;
         w_id_ex_bubble  = 1'b1;
         w_ex_mem_bubble = 1'b1;
         w_mem_wb_bubble = 1'b1;
      end else if (r_state == ERR) begin
         w_pc_pause      = 1'b1;
         w_if_id_pause   = 1'b1;
         w_id_ex_pause   = 1'b1;
         w_ex_mem_pause  = 1'b1;
         w_mem_wb_pause  = 1'b1;
      end else if (w_mw) begin
         w_pc_pause      = 1'b1;
         w_if_id_pause   = 1'b1;
         w_id_ex_pause   = 1'b1;
         w_ex_mem_pause  = 1'b1;
         w_mem_wb_bubble = 1'b1;
      end else if (hif.ex_busy) begin
         w_pc_pause      = 1'b1;
         w_if_id_pause   = 1'b1;
         w_id_ex_pause   = 1'b1;
         w_ex_mem_bubble = 1'b1;
      end else if (hif.ex_br_taken) begin
         w_if_id_bubble  = 1'b1;
         w_id_ex_bubble  = 1'b1;
      end else if (w_lu) begin
         w_pc_pause      = 1'b1;
         w_if_id_pause   = 1'b1;
         w_id_ex_bubble  = 1'b1;
      end
   end

   // State, wait counter, timeout flag and saturating perf counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= RUN;
         r_wait        <= '0;
         r_stall_cnt   <= '0;
         r_flush_cnt   <= '0;
         r_timeout_err <= 1'b0;
      end else if (r_state != ERR) begin
         if (w_stalled && (r_wait == WAIT_LAST)) begin
            r_state       <= ERR;
            r_timeout_err <= 1'b1;
         end else if (w_mw) begin
            r_state <= MEM_WAIT;
         end else if (hif.ex_busy) begin
            r_state <= EX_BUSY;
         end else begin
            r_state <= RUN;
         end
         r_wait <= w_stalled ? r_wait + 1'b1 : '0;
         if (w_pc_pause && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && (r_flush_cnt != CNT_MAX))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign hif.pc_pause      = w_pc_pause;
   assign hif.if_id_pause   = w_if_id_pause;
   assign hif.if_id_bubble  = w_if_id_bubble;
   assign hif.id_ex_pause   = w_id_ex_pause;
   assign hif.id_ex_bubble  = w_id_ex_bubble;
   assign hif.ex_mem_pause  = w_ex_mem_pause;
   assign hif.ex_mem_bubble = w_ex_mem_bubble;
   assign hif.mem_wb_pause  = w_mem_wb_pause;
   assign hif.mem_wb_bubble = w_mem_wb_bubble;
   assign hif.stall_cnt     = r_stall_cnt;
   assign hif.flush_cnt     = r_flush_cnt;
   assign hif.timeout_err   = r_timeout_err;

endmodule
